rv32_core: RTL and testbench



---
 rtl/core_pkg.sv | 51 +++++
 rtl/core_regfile.sv | 26 ++
 rtl/rv32_core.sv | 154 +++++++++++++++
 tb/tb_rv32_core.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared opcodes, funct codes, ALU/writeback enums and ALU decode helper for rv32_core
package core_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_W    = 3'b010;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } alu_op_t;

  typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMMU, WB_AUIPC} wb_sel_t;

  function automatic alu_op_t decodeAlu(input logic [2:0] funct3, input logic alt, input logic isOp);
    case (funct3)
      F3_ADD:  return (isOp && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/core_regfile.sv
// core_regfile: 32x32 register file, 2 async read ports, 1 write port, x0 hardwired, async active-low clear
module core_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rAddr1,
  input  logic [4:0]  rAddr2,
  output logic [31:0] rData1,
  output logic [31:0] rData2,
  input  logic        wEn,
  input  logic [4:0]  wAddr,
  input  logic [31:0] wData
);
  logic [31:0] regs [32];

  // clear everything on reset, otherwise write rd unless it is x0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wEn && wAddr != 5'd0) begin
      regs[wAddr] <= wData;
    end
  end

  assign rData1 = rAddr1 == 5'd0 ? '0 : regs[rAddr1];
  assign rData2 = rAddr2 == 5'd0 ? '0 : regs[rAddr2];
endmodule

// File: rtl/rv32_core.sv
// rv32_core: single-cycle RV32I core; define CORE_MUL_EN to add MUL/MULH/MULHSU/MULHU
module rv32_core
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imemRdata,
  output logic [31:0] imemAddr,
  input  logic [31:0] dmemRdata,
  output logic [31:0] dmemWdata,
  output logic        dmemWen,
  output logic [31:0] dmemAddr
);
  logic [31:0] pc, pcPlus4, nextPc, jalrSum;
  logic [31:0] rs1Val, rs2Val, aluB, aluRes, wbData;
  logic [31:0] immI, immS, immB, immU, immJ;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  funct3;
  logic        regWen, memWen, isBranch, isJal, isJalr, useImm, taken, eq, lt, ltu;
  alu_op_t     aluOp;
  wb_sel_t     wbSel;

  assign opcode = imemRdata[6:0];
  assign rd     = imemRdata[11:7];
  assign funct3 = imemRdata[14:12];
  assign rs1    = imemRdata[19:15];
  assign rs2    = imemRdata[24:20];
  assign funct7 = imemRdata[31:25];

  assign immI = {{20{imemRdata[31]}}, imemRdata[31:20]};
  assign immS = {{20{imemRdata[31]}}, imemRdata[31:25], imemRdata[11:7]};
  assign immB = {{19{imemRdata[31]}}, imemRdata[31], imemRdata[7], imemRdata[30:25], imemRdata[11:8], 1'b0};
  assign immU = {imemRdata[31:12], 12'b0};
  assign immJ = {{11{imemRdata[31]}}, imemRdata[31], imemRdata[19:12], imemRdata[20], imemRdata[30:21], 1'b0};

  core_regfile rf (
    .clk    (clk),
    .rst    (rst),
    .rAddr1 (rs1),
    .rAddr2 (rs2),
    .rData1 (rs1Val),
    .rData2 (rs2Val),
    .wEn    (regWen),
    .wAddr  (rd),
    .wData  (wbData)
  );

  // decode: anything not explicitly recognised stays a NOP (no write, no store, PC+4)
  always_comb begin
    regWen   = 1'b0;
    memWen   = 1'b0;
    isBranch = 1'b0;
    isJal    = 1'b0;
    isJalr   = 1'b0;
    useImm   = 1'b0;
    aluOp    = ALU_ADD;
    wbSel    = WB_ALU;
    case (opcode)
      OPC_LUI:    begin regWen = 1'b1; wbSel = WB_IMMU; end
      OPC_AUIPC:  begin regWen = 1'b1; wbSel = WB_AUIPC; end
      OPC_JAL:    begin regWen = 1'b1; isJal = 1'b1; wbSel = WB_PC4; end
      OPC_JALR:   if (funct3 == 3'b000) begin regWen = 1'b1; isJalr = 1'b1; wbSel = WB_PC4; end
      OPC_BRANCH: isBranch = funct3[2:1] != 2'b01;
      OPC_LOAD:   if (funct3 == F3_W) begin regWen = 1'b1; wbSel = WB_MEM; end
      OPC_STORE:  memWen = funct3 == F3_W;
      OPC_OP_IMM: begin
        regWen = funct3 == F3_SLL ? funct7 == F7_BASE :
                 funct3 == F3_SR  ? (funct7 == F7_BASE || funct7 == F7_ALT) : 1'b1;
        useImm = 1'b1;
        aluOp  = decodeAlu(funct3, funct7[5], 1'b0);
      end
      OPC_OP: begin
        if (funct7 == F7_BASE || (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))) begin
          regWen = 1'b1;
          aluOp  = decodeAlu(funct3, funct7[5], 1'b1);
        end
`ifdef CORE_MUL_EN
        else if (funct7 == F7_MULDIV && !funct3[2]) begin
          regWen = 1'b1;
          aluOp  = funct3[1:0] == 2'b00 ? ALU_MUL :
                   funct3[1:0] == 2'b01 ? ALU_MULH :
                   funct3[1:0] == 2'b10 ? ALU_MULHSU : ALU_MULHU;
        end
`endif
      end
      default: ;
    endcase
  end

  assign aluB  = useImm ? immI : rs2Val;
  assign shamt = aluB[4:0];

`ifdef CORE_MUL_EN
  logic [63:0] prodSS, prodSU, prodUU;
  assign prodSS = {{32{rs1Val[31]}}, rs1Val} * {{32{rs2Val[31]}}, rs2Val};
  assign prodSU = {{32{rs1Val[31]}}, rs1Val} * {32'b0, rs2Val};
  assign prodUU = {32'b0, rs1Val} * {32'b0, rs2Val};
`endif

  // ALU: one result per operation, add is the fallback
  always_comb begin
    aluRes = rs1Val + aluB;
    case (aluOp)
      ALU_SUB:    aluRes = rs1Val - aluB;
      ALU_SLL:    aluRes = rs1Val << shamt;
      ALU_SLT:    aluRes = {31'b0, $signed(rs1Val) < $signed(aluB)};
      ALU_SLTU:   aluRes = {31'b0, rs1Val < aluB};
      ALU_XOR:    aluRes = rs1Val ^ aluB;
      ALU_SRL:    aluRes = rs1Val >> shamt;
      ALU_SRA:    aluRes = $signed(rs1Val) >>> shamt;
      ALU_OR:     aluRes = rs1Val | aluB;
      ALU_AND:    aluRes = rs1Val & aluB;
`ifdef CORE_MUL_EN
      ALU_MUL:    aluRes = prodUU[31:0];
      ALU_MULH:   aluRes = prodSS[63:32];
      ALU_MULHSU: aluRes = prodSU[63:32];
      ALU_MULHU:  aluRes = prodUU[63:32];
`endif
      default:    ;
    endcase
  end

  assign eq    = rs1Val == rs2Val;
  assign lt    = $signed(rs1Val) < $signed(rs2Val);
  assign ltu   = rs1Val < rs2Val;
  assign taken = isBranch && (funct3 == F3_BEQ  ? eq  :
                              funct3 == F3_BNE  ? !eq :
                              funct3 == F3_BLT  ? lt  :
                              funct3 == F3_BGE  ? !lt :
                              funct3 == F3_BLTU ? ltu : !ltu);

  assign pcPlus4 = pc + 32'd4;
  assign jalrSum = rs1Val + immI;
  assign nextPc  = isJalr ? {jalrSum[31:1], 1'b0} :
                   isJal  ? pc + immJ :
                   taken  ? pc + immB : pcPlus4;

  assign wbData = wbSel == WB_MEM   ? dmemRdata :
                  wbSel == WB_PC4   ? pcPlus4 :
                  wbSel == WB_IMMU  ? immU :
                  wbSel == WB_AUIPC ? pc + immU : aluRes;

  assign imemAddr  = pc;
  assign dmemAddr  = rs1Val + (opcode == OPC_STORE ? immS : immI);
  assign dmemWdata = rs2Val;
  assign dmemWen   = memWen && rst;

  // PC advances every edge, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else      pc <= nextPc;
  end
endmodule

// File: tb/tb_rv32_core.sv
// tb_rv32_core: directed self-checking bench for rv32_core with bench-side ROM and RAM
module tb_rv32_core;
  logic        clk, rst;
  logic [31:0] imemRdata, imemAddr, dmemRdata, dmemWdata, dmemAddr;
  logic        dmemWen;
  logic [31:0] rom [64];
  logic [31:0] ram [64];
  int          errors = 0;
  int          checks = 0;

  rv32_core dut (
    .clk       (clk),
    .rst       (rst),
    .imemRdata (imemRdata),
    .imemAddr  (imemAddr),
    .dmemRdata (dmemRdata),
    .dmemWdata (dmemWdata),
    .dmemWen   (dmemWen),
    .dmemAddr  (dmemAddr)
  );

  assign imemRdata = rom[imemAddr[7:2]];
  assign dmemRdata = ram[dmemAddr[7:2]];

  always @(posedge clk) if (dmemWen) ram[dmemAddr[7:2]] <= dmemWdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] encI(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] encR(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] encS(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] encB(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] encJ(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] encU(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] xreg(int i);
    return dut.rf.regs[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clearRom();
    for (int i = 0; i < 64; i++) ram[i] = '0;
    rom[0] = encS(0, 0, 0, 2);
    repeat (3) @(posedge clk);
    #1;
    check("reset_pc", imemAddr, 32'h0);
    check("reset_wen_forced_low", {31'b0, dmemWen}, 32'h0);
    check("reset_ram_untouched", ram[0], 32'h0);

    rom[0]  = encI(-5, 0, 0, 1, 'h13);
    rom[1]  = encI(3, 0, 0, 2, 'h13);
    rom[2]  = encR('h00, 2, 1, 2, 3);
    rom[3]  = encR('h00, 2, 1, 3, 4);
    rom[4]  = encR('h20, 2, 1, 5, 5);
    rom[5]  = encR('h20, 1, 2, 0, 6);
    rom[6]  = encI(28, 1, 5, 7, 'h13);
    rom[7]  = encI(-1, 1, 4, 8, 'h13);
    rom[8]  = encU('h12345, 9, 'h37);
    rom[9]  = encU(1, 10, 'h17);
    rom[10] = encI(7, 0, 0, 0, 'h13);
    rom[11] = 32'h0000_000F;
    rom[12] = encR('h00, 2, 2, 1, 11);
    rom[13] = encR('h01, 5, 5, 3, 12);
    rom[14] = encR('h01, 2, 1, 0, 13);
    rst = 1'b1;
    step(); check("pc_after_1", imemAddr, 32'h4);
    step(); check("pc_after_2", imemAddr, 32'h8);
    step(); check("pc_after_3", imemAddr, 32'hC);
    repeat (12) step();
    check("pc_after_arith", imemAddr, 32'h3C);
    check("addi_neg_x1", xreg(1), 32'hFFFF_FFFB);
    check("addi_x2", xreg(2), 32'h3);
    check("slt_x3", xreg(3), 32'h1);
    check("sltu_x4", xreg(4), 32'h0);
    check("sra_x5", xreg(5), 32'hFFFF_FFFF);
    check("sub_x6", xreg(6), 32'h8);
    check("srli_x7", xreg(7), 32'hF);
    check("xori_x8", xreg(8), 32'h4);
    check("lui_x9", xreg(9), 32'h1234_5000);
    check("auipc_x10", xreg(10), 32'h0000_1024);
    check("x0_stays_zero", xreg(0), 32'h0);
    check("sll_x11", xreg(11), 32'h18);
`ifdef CORE_MUL_EN
    check("mulhu_x12", xreg(12), 32'hFFFF_FFFE);
    check("mul_x13", xreg(13), 32'hFFFF_FFF1);
`else
    check("mulhu_nop_x12", xreg(12), 32'h0);
    check("mul_nop_x13", xreg(13), 32'h0);
`endif

    rst = 1'b0;
    #1;
    check("async_reset_pc", imemAddr, 32'h0);
    check("async_reset_x1", xreg(1), 32'h0);
    clearRom();
    rom[0] = encI('h100, 0, 0, 1, 'h13);
    rom[1] = encI('h55, 0, 0, 2, 'h13);
    rom[2] = encS(4, 2, 1, 2);
    rom[3] = encI(4, 1, 2, 3, 'h03);
    rom[4] = encS(-4, 1, 1, 2);
    step();
    rst = 1'b1;
    step(); step();
    check("sw_wen", {31'b0, dmemWen}, 32'h1);
    check("sw_addr", dmemAddr, 32'h104);
    check("sw_wdata", dmemWdata, 32'h55);
    step();
    check("lw_wen_low", {31'b0, dmemWen}, 32'h0);
    check("ram_captured", ram[1], 32'h55);
    step();
    check("lw_x3", xreg(3), 32'h55);
    check("sw_neg_addr", dmemAddr, 32'hFC);
    check("sw_neg_wdata", dmemWdata, 32'h100);
    #3;
    rst = 1'b0;
    #1;
    check("midrun_reset_pc", imemAddr, 32'h0);
    check("midrun_reset_x3", xreg(3), 32'h0);
    check("midrun_reset_wen", {31'b0, dmemWen}, 32'h0);
    step();
    check("reset_holds_pc", imemAddr, 32'h0);
    check("store_suppressed", ram[63], 32'h0);

    clearRom();
    rom[0]  = encI('h41, 0, 0, 5, 'h13);
    rom[1]  = encB(8, 0, 0, 1);
    rom[2]  = encI(1, 6, 0, 6, 'h13);
    rom[3]  = encJ('h20, 1);
    rom[4]  = encB(-8, 0, 0, 0);
    rom[11] = encI(0, 5, 0, 2, 'h67);
    rom[16] = encJ(-'h30, 0);
    rst = 1'b1;
    step(); check("ctl_pc_4", imemAddr, 32'h4);
    step(); check("bne_not_taken", imemAddr, 32'h8);
    step(); check("ctl_pc_c", imemAddr, 32'hC);
    step(); check("jal_target", imemAddr, 32'h2C);
    check("jal_link_x1", xreg(1), 32'h10);
    step(); check("jalr_target_bit0_cleared", imemAddr, 32'h40);
    check("jalr_link_x2", xreg(2), 32'h30);
    step(); check("jal_backward", imemAddr, 32'h10);
    step(); check("beq_taken_back", imemAddr, 32'h8);
    step(); check("loop_pc_c", imemAddr, 32'hC);
    check("loop_count_x6", xreg(6), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
